// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, one-entry skid buffer and flush.
// Optional statistics counters (stall_cnt, flush_cnt) are enabled by defining PIPE_STAGE_STATS_EN.
module pipe_stage_reg #(
    parameter int DATA_W  = 32,
    parameter int INSTR_W = 32,
    parameter int CTRL_W  = 8,
    parameter int STAT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [CTRL_W-1:0]  in_ctrl,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [INSTR_W-1:0] out_instr,
    output logic [CTRL_W-1:0]  out_ctrl
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [STAT_W-1:0]  stall_cnt,
    output logic [STAT_W-1:0]  flush_cnt
`endif
);

    logic               main_vld_p1;
    logic               skid_vld_p1;
    logic [DATA_W-1:0]  main_data_p1;
    logic [INSTR_W-1:0] main_instr_p1;
    logic [CTRL_W-1:0]  main_ctrl_p1;
    logic [DATA_W-1:0]  skid_data_p1;
    logic [INSTR_W-1:0] skid_instr_p1;
    logic [CTRL_W-1:0]  skid_ctrl_p1;

    logic accept;
    logic drain;
    logic load_main;
    logic load_skid;

    assign accept = in_valid & ~skid_vld_p1;
    assign drain  = main_vld_p1 & out_ready;

    // In SKID the main slot refills from skid; otherwise from the input when main is free or draining.
    assign load_main = skid_vld_p1 ? drain : (accept & (~main_vld_p1 | drain));
    assign load_skid = ~skid_vld_p1 & accept & main_vld_p1 & ~drain;

    // ---- stage boundary: valid bits ----
    always_ff @(posedge clk) begin
        if (rst) begin
            main_vld_p1 <= 1'b0;
            skid_vld_p1 <= 1'b0;
        end else if (flush) begin
            main_vld_p1 <= 1'b0;
            skid_vld_p1 <= 1'b0;
        end else if (skid_vld_p1) begin
            if (drain) skid_vld_p1 <= 1'b0;
        end else if (accept) begin
            main_vld_p1 <= 1'b1;
            if (main_vld_p1 && !drain) skid_vld_p1 <= 1'b1;
        end else if (drain) begin
            main_vld_p1 <= 1'b0;
        end
    end

    // ---- stage boundary: payload (loads during flush are harmless, valid is cleared) ----
    always_ff @(posedge clk) begin
        if (rst) begin
            main_data_p1  <= '0;
            main_instr_p1 <= '0;
            main_ctrl_p1  <= '0;
            skid_data_p1  <= '0;
            skid_instr_p1 <= '0;
            skid_ctrl_p1  <= '0;
        end else begin
            if (load_main) begin
                main_data_p1  <= skid_vld_p1 ? skid_data_p1  : in_data;
                main_instr_p1 <= skid_vld_p1 ? skid_instr_p1 : in_instr;
                main_ctrl_p1  <= skid_vld_p1 ? skid_ctrl_p1  : in_ctrl;
            end
            if (load_skid) begin
                skid_data_p1  <= in_data;
                skid_instr_p1 <= in_instr;
                skid_ctrl_p1  <= in_ctrl;
            end
        end
    end

    assign in_ready  = ~skid_vld_p1;
    assign out_valid = main_vld_p1;
    assign out_data  = main_data_p1;
    assign out_instr = main_instr_p1;
    assign out_ctrl  = main_vld_p1 ? main_ctrl_p1 : '0;

`ifdef PIPE_STAGE_STATS_EN
    function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a,
                                                  input logic [1:0]        inc);
        logic [STAT_W:0] sum;
        sum = {1'b0, a} + (STAT_W+1)'(inc);
        return sum[STAT_W] ? {STAT_W{1'b1}} : sum[STAT_W-1:0];
    endfunction

    logic [1:0] discard;
    logic       stalled;

    // Entries lost on a flush: a non-draining main, the skid, and a dropped accept (never all three).
    assign stalled = main_vld_p1 & ~out_ready;
    assign discard = {1'b0, stalled} + {1'b0, skid_vld_p1} + {1'b0, accept};

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            stall_cnt <= sat_add(stall_cnt, {1'b0, stalled});
            if (flush) flush_cnt <= sat_add(flush_cnt, discard);
        end
    end
`else
    logic [STAT_W-1:0] unused_stat_w;
    assign unused_stat_w = '0;
`endif

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Generic, parametrised inter-stage pipeline register with a valid/ready handshake, a one-entry skid buffer, and a synchronous flush. It carries a data word, the instruction word and a packed control bundle from one stage to the next. It is the drop-in successor for the fixed per-stage registers (ID/EX, EX/MEM, MEM/WB). It adds back-pressure, bubble insertion and flush, which the fixed registers lack.

## Interface
- DATA_W, 32: width of the data payload (ALU result / operand word).
- INSTR_W, 32: width of the instruction word carried alongside.
- CTRL_W, 8: width of the packed control bundle (mem write/read, RF write enable, write-back selects, ...).
- STAT_W, 16: width of the statistics counters (only with PIPE_STAGE_STATS_EN).
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept; equals NOT skid_valid, taken straight from a flop.
- in_data  in  DATA_W  upstream payload.
- in_instr  in  INSTR_W  upstream instruction.
- in_ctrl  in  CTRL_W  upstream control bundle.
- flush  in  1  discard all held and incoming entries.
- out_valid  out  1  main entry present.
- out_ready  in  1  downstream accepts the main entry.
- out_data  out  DATA_W  main-entry payload.
- out_instr  out  INSTR_W  main-entry instruction.
- out_ctrl  out  CTRL_W  main-entry control; forced to 0 whenever out_valid=0, so a bubble carries no write enables.
- stall_cnt  out  STAT_W  cycles with out_valid=1 and out_ready=0 (macro only).
- flush_cnt  out  STAT_W  valid entries discarded by flush (macro only).

## Operation
- Accept happens when in_valid and in_ready are both 1. Drain happens when out_valid and out_ready are both 1.
- The block has three states, encoded by (main_valid, skid_valid):
  - EMPTY (0,0)
  - FULL (1,0)
  - SKID (1,1)
- EMPTY:
  - Accept: load main and go to FULL.
  - No accept: stay in EMPTY.
- FULL:
  - Accept and drain: load main with the new entry and stay in FULL.
  - Accept without drain: write the entry into skid and go to SKID.
  - Drain without accept: go to EMPTY.
  - Neither: hold.
- SKID:
  - in_ready=0, so no accept is possible.
  - Drain: move skid into main and go to FULL.
  - No drain: hold both entries unchanged.
- Ordering is strictly FIFO: skid is always younger than main.
- Flush has priority over everything else:
  - Next state is EMPTY.
  - An accept in the same cycle is dropped.
  - A drain in the same cycle still completes downstream.
- Payload registers are not cleared on flush, only the valid bits. out_data and out_instr are don't-care while out_valid=0. out_ctrl is gated to 0.
- Reset (any cycle, including mid-stall): next state is EMPTY, all payload registers cleared to 0, counters cleared to 0.

## Timing
- Latency: an entry accepted at edge N is visible on out_* after edge N, i.e. one cycle.
- Throughput: one entry per cycle while out_ready=1.
- in_ready has no combinational path from out_ready. There is no combinational path from any input to any output except the out_ctrl gating by the internal valid bit.
- Reset values:
  - out_valid=0, in_ready=1, out_data=0, out_instr=0, out_ctrl=0.
  - stall_cnt=0, flush_cnt=0.
- in_ready=1 in the first cycle after rst deasserts.
- Flush takes effect at the edge on which it is sampled. out_valid=0 and in_ready=1 from the next cycle.
- Counters saturate at 2^STAT_W−1 and do not wrap.

## Configuration
- PIPE_STAGE_STATS_EN
  - Defined: the stall_cnt and flush_cnt ports and their counters exist. flush_cnt adds the number of valid entries (0, 1 or 2) discarded on each flush cycle, counting a dropped in-flight accept as 1. Both counters saturate.
  - Undefined: the ports and counters are absent. All other behaviour is identical.

## Test plan
- Streaming: out_ready=1; send instr 0x1..0x8 back-to-back → out_valid high from cycle 2, out_instr 0x1..0x8 in order with no gaps, in_ready stays 1.
- Skid: hold out_ready=0 while sending A=0x11, B=0x22 → after 2 cycles state is SKID, in_ready=0, out_instr=0x11. Release out_ready → 0x11 then 0x22 are delivered, in_ready returns to 1 one cycle after 0x11 drains.
- Bubble gating: in_valid=0 with in_ctrl=0xFF → out_valid=0 and out_ctrl=0x00.
- Flush while in SKID with in_valid=1 → next cycle out_valid=0, in_ready=1. With the macro defined, flush_cnt increases by 2 (skid blocks the accept).
- Flush in FULL with out_ready=0 and accept → flush_cnt +2. Stall of 5 cycles → stall_cnt=5. Preload STAT_W=4 saturation → stall_cnt holds at 15.
- Reset asserted mid-SKID for 1 cycle → outputs return to reset values. in_ready=1 and the first post-reset entry passes with one-cycle latency.
